data_loader: RTL and testbench
==============================

Name: data_loader

Overview:
- Upstream fill stage for the training-data BRAM.
- Accepts a byte stream (e.g. from the UART receiver) and packs it into BRAM_WIDTH-bit words.
- Writes the words sequentially into the data BRAM port, so the data medium can later read {x, y} samples.
- Owns the BRAM write port while loading. It signals completion so the CPU/controller can start training.

Parameters:
- ADDRS, 1024, number of samples (x,y pairs) held in BRAM.
- BRAM_WIDTH, 64, BRAM word width in bits; must be a multiple of 8.
- PIECES, 16, BRAM words per x vector (and per y vector).
- Derived, not overridable: BYTES_PER_WORD = BRAM_WIDTH/8; WORDS = ADDRS*PIECES*2; BRAM_ADDR_SIZE = $clog2(WORDS).

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous active-high reset.
- start_in  input  1  one-cycle request to begin a full load.
- byte_in  input  8  incoming data byte.
- byte_valid_in  input  1  byte_in valid this cycle.
- byte_ready_out  output  1  loader accepts a byte this cycle.
- busy_out  output  1  high while loading.
- finished_out  output  1  one-cycle pulse when the last word is written.
- loaded_out  output  1  level; high from finish until the next start or reset.
- checksum_out  output  8  running XOR of all accepted bytes since the last start.
- bram_addr  output  BRAM_ADDR_SIZE  BRAM word address.
- bram_we  output  1  BRAM write enable.
- bram_regce  output  1  tied 0 (loader never reads).
- bram_din  output  BRAM_WIDTH  BRAM write data.

Behaviour:
- Reset: all outputs 0; state IDLE; byte index, word counter and assembly register cleared. Reset mid-load abandons the load; BRAM contents are then undefined, and loaded_out stays 0 until a full load completes.
- States: IDLE, LOAD, DONE.
- IDLE:
  - byte_ready_out=0.
  - start_in=1 -> LOAD next cycle; clears word_cnt, byte_idx, checksum_out and loaded_out.
  - byte_valid_in is ignored; no byte is consumed.
- LOAD:
  - byte_ready_out=1 combinationally.
  - A byte is accepted on any cycle with byte_valid_in & byte_ready_out.
  - Each accepted byte goes to assembly[8*byte_idx +: 8] (little-endian: first byte is the LSB). byte_idx increments, and checksum_out ^= byte_in on the same edge.
  - When the accepted byte has byte_idx = BYTES_PER_WORD-1, on that edge:
    - bram_din <= {byte_in, assembly[BRAM_WIDTH-9:0]};
    - bram_addr <= word_cnt; bram_we <= 1;
    - word_cnt++; byte_idx <= 0.
  - bram_we is 1 for exactly that one following cycle. Latency: last byte of a word accepted at edge N -> write visible at edge N+1.
  - Back-to-back bytes are sustained with no stalls; gaps in byte_valid_in simply pause assembly.
  - start_in is ignored while in LOAD.
  - When the completed word is word WORDS-1: transition to DONE on the same edge. finished_out=1 during the cycle bram_we=1 for that word. busy_out drops that same cycle.
- DONE:
  - byte_ready_out=0; loaded_out=1; finished_out=0 after its single pulse.
  - start_in=1 -> LOAD, clearing as in IDLE.
- busy_out = (state==LOAD), registered.
- BRAM layout (fixed, must match the data medium read order):
  - word address = sample*2*PIECES + k, for k in 0..2*PIECES-1.
  - Word k holds bits [BRAM_WIDTH*k +: BRAM_WIDTH] of the concatenation {x, y}.
  - The loader writes linearly; the byte stream must already be in this order.
- bram_addr holds its last value when bram_we=0.
- word_cnt is BRAM_ADDR_SIZE+1 bits wide, so no wrap occurs before the compare.
- After DONE no writes occur, even if more bytes arrive.

Test Plan:
- ADDRS=2, PIECES=2, BRAM_WIDTH=16 (8 words). Start, then stream bytes 0x01..0x10 back-to-back -> writes (addr, din) = (0,0x0201), (1,0x0403) … (7,0x100F). finished_out pulses with the addr-7 write; loaded_out=1; checksum_out=0x10; busy_out=0.
- Same stream with byte_valid_in low every other cycle -> identical write sequence and checksum; each bram_we lasts exactly one cycle.
- byte_valid_in=1 with 0xAA while IDLE for 5 cycles, then start and normal stream -> byte_ready_out=0 in IDLE, no writes, first write is (0,0x0201).
- Pulse start_in mid-load after 3 words -> ignored; load completes with 8 writes total, addresses 0..7, in order.
- Assert rst_in after 5 bytes -> next cycle all outputs 0. Then start and a full stream -> first write at addr 0 with data from the new stream; checksum is computed from the new stream only.
- After DONE, keep sending bytes, then start again with bytes 0x11..0x20 -> no writes before the start; loaded_out clears on start; reload writes (0,0x1211) … (7,0x201F).

Source files
------------

// File: rtl/data_loader.sv
// data_loader: fill stage for the training-data BRAM.
// Packs an incoming byte stream (little-endian, first byte -> LSB) into
// BRAM_WIDTH-bit words and writes them to consecutive BRAM addresses
// 0..WORDS-1. It owns the BRAM write port while loading and reports
// completion with a one-cycle pulse plus a sticky "loaded" level.
//
// Ports:
//   clk_in          system clock
//   rst_in          synchronous active-high reset
//   start_in        one-cycle request to begin a full load (IDLE/DONE only)
//   byte_in         incoming data byte
//   byte_valid_in   byte_in valid this cycle
//   byte_ready_out  loader accepts a byte this cycle (combinational, LOAD)
//   busy_out        high while loading
//   finished_out    one-cycle pulse coinciding with the final word write
//   loaded_out      high from finish until the next start or reset
//   checksum_out    XOR of all bytes accepted since the last start
//   bram_addr       BRAM word address (holds when bram_we is low)
//   bram_we         BRAM write enable, one cycle per completed word
//   bram_regce      BRAM output register enable, always 0
//   bram_din        BRAM write data
module data_loader #(
    parameter int unsigned ADDRS      = 1024,
    parameter int unsigned BRAM_WIDTH = 64,
    parameter int unsigned PIECES     = 16,
    localparam int unsigned BYTES_PER_WORD = BRAM_WIDTH / 8,
    localparam int unsigned WORDS          = ADDRS * PIECES * 2,
    localparam int unsigned BRAM_ADDR_SIZE = $clog2(WORDS)
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      start_in,
    input  logic [7:0]                byte_in,
    input  logic                      byte_valid_in,
    output logic                      byte_ready_out,
    output logic                      busy_out,
    output logic                      finished_out,
    output logic                      loaded_out,
    output logic [7:0]                checksum_out,
    output logic [BRAM_ADDR_SIZE-1:0] bram_addr,
    output logic                      bram_we,
    output logic                      bram_regce,
    output logic [BRAM_WIDTH-1:0]     bram_din
);

    // Byte index needs at least one bit even for single-byte words.
    localparam int unsigned IDX_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    // One extra bit so the count never wraps before the final compare.
    localparam int unsigned CNT_W = BRAM_ADDR_SIZE + 1;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(BYTES_PER_WORD - 1);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state;
    logic [IDX_W-1:0]        byte_idx;
    logic [CNT_W-1:0]        word_cnt;
    logic [BRAM_WIDTH-1:0]   assembly;
    logic [BRAM_WIDTH-1:0]   word_c;

    // Assembly register with the current byte merged in at its lane; on the
    // last byte of a word this is exactly the word to be written.
    always_comb begin
        word_c = assembly;
        word_c[{byte_idx, 3'b000} +: 8] = byte_in;
    end

    assign byte_ready_out = (state == LOAD);
    assign bram_regce     = 1'b0;

    // Load sequencer, byte packer and BRAM write port.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state        <= IDLE;
            byte_idx     <= '0;
            word_cnt     <= '0;
            assembly     <= '0;
            busy_out     <= 1'b0;
            finished_out <= 1'b0;
            loaded_out   <= 1'b0;
            checksum_out <= '0;
            bram_addr    <= '0;
            bram_we      <= 1'b0;
            bram_din     <= '0;
        end else begin
            bram_we      <= 1'b0;
            finished_out <= 1'b0;

            case (state)
                IDLE, DONE: begin
                    if (start_in) begin
                        state        <= LOAD;
                        busy_out     <= 1'b1;
                        loaded_out   <= 1'b0;
                        word_cnt     <= '0;
                        byte_idx     <= '0;
                        checksum_out <= '0;
                    end
                end

                LOAD: begin
                    if (byte_valid_in) begin
                        checksum_out <= checksum_out ^ byte_in;
                        assembly     <= word_c;
                        if (byte_idx == LAST_IDX) begin
                            byte_idx  <= '0;
                            bram_din  <= word_c;
                            bram_addr <= word_cnt[BRAM_ADDR_SIZE-1:0];
                            bram_we   <= 1'b1;
                            word_cnt  <= word_cnt + CNT_W'(1);
                            // Final word: leave LOAD on the same edge as its write.
                            if (word_cnt == LAST_WORD) begin
                                state        <= DONE;
                                busy_out     <= 1'b0;
                                finished_out <= 1'b1;
                                loaded_out   <= 1'b1;
                            end
                        end else begin
                            byte_idx <= byte_idx + IDX_W'(1);
                        end
                    end
                end

                default: begin
                    state    <= IDLE;
                    busy_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_loader.sv
// tb_data_loader: scoreboard bench for data_loader with a small geometry
// (2 samples, 2 pieces, 16-bit words -> 8 words). The driver models the
// packing and pushes expected writes; a monitor pops them on each bram_we.
module tb_data_loader;

    localparam int unsigned ADDRS      = 2;
    localparam int unsigned PIECES     = 2;
    localparam int unsigned BRAM_WIDTH = 16;
    localparam int unsigned BPW        = BRAM_WIDTH / 8;
    localparam int unsigned WORDS      = ADDRS * PIECES * 2;
    localparam int unsigned AW         = $clog2(WORDS);

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic [7:0]            byte_data;
    logic                  byte_valid;
    logic                  byte_ready;
    logic                  busy;
    logic                  finished;
    logic                  loaded;
    logic [7:0]            checksum;
    logic [AW-1:0]         bram_addr;
    logic                  bram_we;
    logic                  bram_regce;
    logic [BRAM_WIDTH-1:0] bram_din;

    always #5 clk = ~clk;

    data_loader #(
        .ADDRS      (ADDRS),
        .BRAM_WIDTH (BRAM_WIDTH),
        .PIECES     (PIECES)
    ) dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .start_in       (start),
        .byte_in        (byte_data),
        .byte_valid_in  (byte_valid),
        .byte_ready_out (byte_ready),
        .busy_out       (busy),
        .finished_out   (finished),
        .loaded_out     (loaded),
        .checksum_out   (checksum),
        .bram_addr      (bram_addr),
        .bram_we        (bram_we),
        .bram_regce     (bram_regce),
        .bram_din       (bram_din)
    );

    typedef struct packed {
        logic [AW-1:0]         addr;
        logic [BRAM_WIDTH-1:0] din;
        logic                  fin;
    } wr_t;

    wr_t                   exp_q[$];
    int                    checks = 0;
    int                    errors = 0;

    // Reference model state
    bit                    m_load = 1'b0;
    int                    m_idx  = 0;
    int                    m_cnt  = 0;
    logic [BRAM_WIDTH-1:0] m_asm  = '0;
    logic [7:0]            m_ck   = '0;
    int                    wr_seen = 0;
    logic                  prev_we = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Write monitor: every bram_we must match the head of the scoreboard.
    always @(negedge clk) begin
        wr_t e;
        if (rst) begin
            prev_we = 1'b0;
        end else begin
            if (bram_we) begin
                wr_seen++;
                check("we_single_cycle", 32'(prev_we), 32'(0));
                check("regce", 32'(bram_regce), 32'(0));
                check("write_expected", 32'(exp_q.size() != 0), 32'(1));
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(bram_addr), 32'(e.addr));
                    check("wr_din", 32'(bram_din), 32'(e.din));
                    check("wr_fin", 32'(finished), 32'(e.fin));
                end
            end else if (finished) begin
                check("fin_with_we", 32'(bram_we), 32'(1));
            end
            prev_we = bram_we;
        end
    end

    task automatic drive_byte(input logic [7:0] b);
        @(negedge clk);
        byte_data  = b;
        byte_valid = 1'b1;
        check("ready", 32'(byte_ready), 32'(m_load));
        check("busy", 32'(busy), 32'(m_load));
        if (m_load) begin
            m_ck = m_ck ^ b;
            m_asm[8*m_idx +: 8] = b;
            if (m_idx == int'(BPW) - 1) begin
                exp_q.push_back('{addr: AW'(m_cnt), din: m_asm, fin: (m_cnt == int'(WORDS) - 1)});
                m_idx = 0;
                m_cnt++;
                if (m_cnt == int'(WORDS)) m_load = 1'b0;
            end else begin
                m_idx++;
            end
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        byte_valid = 1'b0;
        start      = 1'b0;
    endtask

    // Start pulse; the model only restarts when the DUT is not loading.
    task automatic do_start();
        @(negedge clk);
        start      = 1'b1;
        byte_valid = 1'b0;
        if (!m_load) begin
            m_load  = 1'b1;
            m_idx   = 0;
            m_cnt   = 0;
            m_ck    = '0;
            wr_seen = 0;
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic stream(input logic [7:0] first, input bit gap);
        for (int i = 0; i < int'(WORDS * BPW); i++) begin
            drive_byte(first + 8'(i));
            if (gap) idle_cycle();
        end
        idle_cycle();
    endtask

    task automatic finish_checks(input string tag);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        check({tag, "_drain"}, 32'(exp_q.size()), 32'(0));
        @(negedge clk);
        check({tag, "_writes"}, 32'(wr_seen), 32'(WORDS));
        check({tag, "_loaded"}, 32'(loaded), 32'(1));
        check({tag, "_busy"}, 32'(busy), 32'(0));
        check({tag, "_fin_low"}, 32'(finished), 32'(0));
        check({tag, "_cksum"}, 32'(checksum), 32'(m_ck));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'(0));
        check({tag, "_fin"}, 32'(finished), 32'(0));
        check({tag, "_loaded"}, 32'(loaded), 32'(0));
        check({tag, "_cksum"}, 32'(checksum), 32'(0));
        check({tag, "_addr"}, 32'(bram_addr), 32'(0));
        check({tag, "_we"}, 32'(bram_we), 32'(0));
        check({tag, "_din"}, 32'(bram_din), 32'(0));
        check({tag, "_ready"}, 32'(byte_ready), 32'(0));
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst        = 1'b1;
        byte_valid = 1'b0;
        start      = 1'b0;
        @(negedge clk);
        check_zero("reset");
        rst    = 1'b0;
        m_load = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        byte_data  = '0;
        byte_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("por");
        rst = 1'b0;

        // Back-to-back stream 0x01..0x10
        do_start();
        stream(8'h01, 1'b0);
        finish_checks("b2b");
        check("b2b_cksum_lit", 32'(checksum), 32'(8'h10));

        // Same stream with valid low every other cycle
        do_start();
        stream(8'h01, 1'b1);
        finish_checks("gap");

        // Bytes offered while IDLE are ignored
        apply_reset();
        for (int i = 0; i < 5; i++) drive_byte(8'hAA);
        idle_cycle();
        check("idle_cksum", 32'(checksum), 32'(0));
        do_start();
        stream(8'h01, 1'b0);
        finish_checks("idle");

        // start_in mid-load is ignored
        do_start();
        for (int i = 0; i < 6; i++) drive_byte(8'h01 + 8'(i));
        do_start();
        for (int i = 6; i < 16; i++) drive_byte(8'h01 + 8'(i));
        idle_cycle();
        finish_checks("midstart");

        // Reset after 5 bytes abandons the load
        do_start();
        for (int i = 0; i < 5; i++) drive_byte(8'h01 + 8'(i));
        apply_reset();
        do_start();
        stream(8'h41, 1'b0);
        finish_checks("rstload");

        // Bytes after DONE are ignored; reload with 0x11..0x20
        for (int i = 0; i < 4; i++) drive_byte(8'h55);
        idle_cycle();
        check("done_loaded_hold", 32'(loaded), 32'(1));
        do_start();
        check("reload_loaded_clr", 32'(loaded), 32'(0));
        stream(8'h11, 1'b0);
        finish_checks("reload");
        check("reload_cksum_lit", 32'(checksum), 32'(8'h30));

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
